demux1to4_reg: RTL and testbench
================================

Name: demux1to4_reg

Overview:
- Registered 1-to-4 demultiplexer: the distributing end of our 4-to-1 selection datapath.
- Takes one N-bit word stream with a valid/ready handshake and routes each word to one of four output channels.
- Each channel has its own one-entry output register and valid/ready handshake.
- Target channel comes from an explicit select, or from an internal round-robin pointer in auto mode.

Parameters:
N, 32, data width in bits of the input and of every output channel

Ports:
i_clk  input  1  clock; all state changes on the rising edge
i_rst  input  1  synchronous reset, active-high
i_valid  input  1  input word present
o_ready  output  1  block can accept the input word this cycle
i_data  input  N  input word
i_sel  input  2  explicit target channel; used when i_auto=0
i_auto  input  1  1 = route by internal round-robin pointer, 0 = route by i_sel
o_ptr  output  2  current round-robin pointer value
o_valid  output  4  bit k = channel k holds a word
i_ready  input  4  bit k = consumer of channel k takes the word this cycle
o_data0  output  N  channel 0 word
o_data1  output  N  channel 1 word
o_data2  output  N  channel 2 word
o_data3  output  N  channel 3 word

Behaviour:
- Reset: the clock edge with i_rst=1 forces o_valid=4'b0000, o_data0..3=0, ptr=0.
  - Reset overrides every other event in that cycle.
  - Words still held in channel registers are discarded; nothing is delivered after reset.
- Target channel: t = i_auto ? ptr : i_sel (combinational, same cycle).
- o_ready = ~o_valid[t] | i_ready[t].
  - This is a combinational path from i_ready, i_sel and i_auto to o_ready.
  - It does not depend on i_valid.
- Accept: i_valid & o_ready.
  - On that edge, channel t's data register <= i_data and o_valid[t] <= 1.
  - Latency is 1 cycle: the word is visible on o_data<t> and o_valid[t] in the cycle after accept.
- Drain: in any cycle with o_valid[k] & i_ready[k], channel k's word is consumed. If channel k is not loaded on the same edge, o_valid[k] <= 0.
- Load and drain on the same channel in the same cycle: o_valid stays 1 and the data register takes the new word. No bubble, no loss.
- Channels are independent:
  - Draining a non-target channel happens in parallel with an accept into the target channel.
  - All four channels may drain in the same cycle.
- Stability:
  - While o_valid[k]=1 and i_ready[k]=0, o_data<k> does not change.
  - A data register changes only on an accept to that channel or on reset.
  - While o_valid[k]=0, o_data<k> keeps its last value; it is don't-care for the consumer.
- i_valid=0: no state change except drains. i_data and i_sel are ignored.
- Round-robin pointer:
  - ptr increments by 1 mod 4 (3 -> 0) on each accept while i_auto=1.
  - ptr holds when there is no accept or when i_auto=0.
  - o_ptr = ptr (registered).
- Mode switching: i_auto may change on any cycle. Routing for that cycle uses the new value and ptr keeps its held value. Switching does not reset the pointer.
- Stall: if the target channel is full and its i_ready=0, o_ready=0. The source must hold i_valid/i_data. Other channels continue draining.
- Order is preserved per channel. With i_auto=1, words land strictly in order 0,1,2,3,0,...; a blocked channel stalls the stream, it is never skipped.
- Protocol: the source may not withdraw i_valid before acceptance. The bench checks this; the block does not.

Test Plan:
- Reset then explicit route, N=32: i_rst=1 for 2 cycles -> o_valid=0000, o_ptr=0, all o_data=0. Then i_auto=0, i_sel=2, i_valid=1, i_data=32'hA5A5_0002 with i_ready=0000 -> next cycle o_valid=0100, o_data2=A5A5_0002. Second word to sel=2 -> o_ready=0 and the source holds. Set i_ready[2]=1 -> the second word is accepted and o_valid[2] stays 1.
- Auto round-robin wrap: i_auto=1, i_ready=1111, words 1..6 on consecutive cycles -> channels 0,1,2,3,0,1 receive them. o_ptr sequence after each accept is 1,2,3,0,1,2. Every accept has o_ready=1.
- Blocked channel in auto mode: ptr=1, i_ready=1101, channel 1 already full -> o_ready=0 and ptr stays 1, while channels 0/2/3 still drain. Raise i_ready[1] -> the word goes to channel 1 and ptr becomes 2.
- Same-cycle load and drain: channel 3 holds 32'h0000_0033, i_ready[3]=1, accept 32'h0000_0044 to sel=3 -> next cycle o_valid[3]=1 and o_data3=0000_0044. Next cycle with i_valid=0 -> o_valid[3]=0.
- Mid-operation reset: all four channels full, i_ready=0000, ptr=2. Assert i_rst for one cycle with i_valid=1 -> o_valid=0000, all o_data=0, o_ptr=0. The word presented during reset is not captured.
- Stall stability: channel 0 full with 32'hDEAD_BEEF, i_ready[0]=0 for 10 cycles while i_data toggles randomly and i_sel=0 -> o_data0 stays DEAD_BEEF and o_ready stays 0 throughout.

Source files
------------

// File: rtl/demux1to4_reg_if.sv
// demux1to4_reg_if: bundles the bus of the registered 1-to-4 demultiplexer.
//   Source side : i_valid, i_data, i_sel, i_auto   -> block ; o_ready back
//   Consumer side: o_valid[3:0], o_data0..3, o_ptr -> consumers ; i_ready[3:0] back
// The master modport is the environment (source plus the four consumers);
// the slave modport is the demultiplexer itself.
interface demux1to4_reg_if #(
   parameter int N = 32
);
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] i_data;
   logic [1:0]   i_sel;
   logic         i_auto;
   logic [1:0]   o_ptr;
   logic [3:0]   o_valid;
   logic [3:0]   i_ready;
   logic [N-1:0] o_data0;
   logic [N-1:0] o_data1;
   logic [N-1:0] o_data2;
   logic [N-1:0] o_data3;

   modport master (
      output i_valid, i_data, i_sel, i_auto, i_ready,
      input  o_ready, o_ptr, o_valid, o_data0, o_data1, o_data2, o_data3
   );

   modport slave (
      input  i_valid, i_data, i_sel, i_auto, i_ready,
      output o_ready, o_ptr, o_valid, o_data0, o_data1, o_data2, o_data3
   );
endinterface

// File: rtl/demux1to4_reg.sv
// demux1to4_reg: registered 1-to-4 demultiplexer with per-channel one-entry
// output registers and valid/ready handshakes on both sides.
// Ports:
//   i_clk  - clock, all state changes on the rising edge
//   i_rst  - synchronous reset, active-high; clears channels and pointer
//   bus    - demux1to4_reg_if.slave: input word stream (i_valid/o_ready/
//            i_data), routing controls (i_sel/i_auto), pointer (o_ptr) and
//            the four output channels (o_valid/i_ready/o_data0..3)
// Routing: target = i_auto ? round-robin pointer : i_sel. A blocked target
// stalls the input; it is never skipped, so per-channel order is preserved.
module demux1to4_reg #(
   parameter int N = 32
) (
   input  logic           i_clk,
   input  logic           i_rst,
   demux1to4_reg_if.slave bus
);

   logic [1:0]   ptr_r;
   logic [3:0]   valid_r;
   logic [N-1:0] data_r [4];

   logic [1:0]   tgt_s;
   logic         ready_s;
   logic         accept_s;
   logic [3:0]   load_s;
   logic [3:0]   valid_nxt_s;
   logic [1:0]   ptr_nxt_s;

   // Target selection, input handshake and next-state of flags and pointer
   always_comb begin
      tgt_s       = 2'd0;
      ready_s     = 1'b0;
      accept_s    = 1'b0;
      load_s      = 4'b0000;
      valid_nxt_s = valid_r;
      ptr_nxt_s   = ptr_r;

      if (bus.i_auto) begin
         tgt_s = ptr_r;
      end else begin
         tgt_s = bus.i_sel;
      end

      // A full target can still accept when its consumer drains it this cycle.
      ready_s  = ~valid_r[tgt_s] | bus.i_ready[tgt_s];
      accept_s = bus.i_valid & ready_s;

      if (accept_s) begin
         load_s = 4'b0001 << tgt_s;
      end else begin
         load_s = 4'b0000;
      end

      // Drains clear their flag; a load on the same edge sets it again.
      valid_nxt_s = (valid_r & ~bus.i_ready) | load_s;

      if (accept_s & bus.i_auto) begin
         ptr_nxt_s = ptr_r + 2'd1;
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   // Channel flags, channel data registers and round-robin pointer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_r <= 4'b0000;
         ptr_r   <= 2'd0;
         for (int k = 0; k < 4; k++) begin
            data_r[k] <= {N{1'b0}};
         end
      end else begin
         valid_r <= valid_nxt_s;
         ptr_r   <= ptr_nxt_s;
         for (int k = 0; k < 4; k++) begin
            if (load_s[k]) begin
               data_r[k] <= bus.i_data;
            end
         end
      end
   end

   assign bus.o_ready = ready_s;
   assign bus.o_ptr   = ptr_r;
   assign bus.o_valid = valid_r;
   assign bus.o_data0 = data_r[0];
   assign bus.o_data1 = data_r[1];
   assign bus.o_data2 = data_r[2];
   assign bus.o_data3 = data_r[3];

endmodule

// File: tb/tb_demux1to4_reg.sv
// tb_demux1to4_reg: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a channel-occupancy model.
module tb_demux1to4_reg;
   localparam int N = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   demux1to4_reg_if #(.N(N)) bus ();
   demux1to4_reg #(.N(N)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   // Model: each channel is a slot that is either full or empty and
   // remembers its last word; the pointer is a plain integer mod 4.
   bit           m_full [4];
   logic [N-1:0] m_data [4];
   int           m_ptr;
   bit           m_acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_tgt();
      return bus.i_auto ? m_ptr : int'(bus.i_sel);
   endfunction

   function automatic bit m_ready();
      int t;
      t = m_tgt();
      return !m_full[t] || bus.i_ready[t];
   endfunction

   function automatic logic [N-1:0] dut_data(input int k);
      case (k)
         0: return bus.o_data0;
         1: return bus.o_data1;
         2: return bus.o_data2;
         default: return bus.o_data3;
      endcase
   endfunction

   // Reference model update on every rising edge
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            m_full[k] <= 1'b0;
            m_data[k] <= '0;
         end
         m_ptr <= 0;
         m_acc <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (m_full[k] && bus.i_ready[k]) m_full[k] <= 1'b0;
         end
         if (bus.i_valid && m_ready()) begin
            m_full[m_tgt()] <= 1'b1;
            m_data[m_tgt()] <= bus.i_data;
            if (bus.i_auto) m_ptr <= (m_ptr + 1) % 4;
         end
         m_acc <= bus.i_valid && m_ready();
      end
   end

   // Per-cycle comparison of all DUT outputs against the model
   always @(negedge clk) begin
      #2;
      if (cmp_en) begin
         chk("o_valid", 32'(bus.o_valid),
             32'({m_full[3], m_full[2], m_full[1], m_full[0]}));
         chk("o_ptr", 32'(bus.o_ptr), 32'(m_ptr));
         chk("o_ready", 32'(bus.o_ready), 32'(m_ready()));
         for (int k = 0; k < 4; k++) chk("o_data", dut_data(k), m_data[k]);
      end
   end

   task automatic drv(input logic v, input logic [N-1:0] d, input logic [1:0] s,
                      input logic a, input logic [3:0] r);
      bus.i_valid = v;
      bus.i_data  = d;
      bus.i_sel   = s;
      bus.i_auto  = a;
      bus.i_ready = r;
   endtask

   initial begin
      rst = 1'b1;
      drv(1'b0, 32'h0, 2'd0, 1'b0, 4'b0000);

      // Reset for two edges, then explicit route to channel 2
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      drv(1'b1, 32'hA5A5_0002, 2'd2, 1'b0, 4'b0000);
      #3;
      chk("rst_valid", 32'(bus.o_valid), 32'h0);
      chk("rst_ptr", 32'(bus.o_ptr), 32'h0);
      for (int k = 0; k < 4; k++) chk("rst_data", dut_data(k), 32'h0);
      chk("sel2_ready", 32'(bus.o_ready), 32'h1);

      @(negedge clk);
      drv(1'b1, 32'hA5A5_1002, 2'd2, 1'b0, 4'b0000);
      #3;
      chk("sel2_valid", 32'(bus.o_valid), 32'h4);
      chk("sel2_data", bus.o_data2, 32'hA5A5_0002);
      chk("full_stall", 32'(bus.o_ready), 32'h0);

      @(negedge clk);
      drv(1'b1, 32'hA5A5_1002, 2'd2, 1'b0, 4'b0100);
      #3;
      chk("hold_data", bus.o_data2, 32'hA5A5_0002);
      chk("drain_ready", 32'(bus.o_ready), 32'h1);

      @(negedge clk);
      drv(1'b0, 32'h0, 2'd0, 1'b0, 4'b0000);
      #3;
      chk("second_valid", 32'(bus.o_valid), 32'h4);
      chk("second_data", bus.o_data2, 32'hA5A5_1002);

      // Auto round-robin across the wrap
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         drv(1'b1, 32'(i), 2'd3, 1'b1, 4'b1111);
         #3;
         if (i > 1) begin
            chk("rr_ptr", 32'(bus.o_ptr), 32'((i - 1) % 4));
            chk("rr_data", dut_data((i - 2) % 4), 32'(i - 1));
         end else begin
            chk("rr_ptr0", 32'(bus.o_ptr), 32'h0);
         end
         chk("rr_ready", 32'(bus.o_ready), 32'h1);
      end
      @(negedge clk);
      drv(1'b0, 32'h0, 2'd0, 1'b1, 4'b1111);
      #3;
      chk("rr_ptr_end", 32'(bus.o_ptr), 32'h2);
      chk("rr_data_end", bus.o_data1, 32'h6);

      // Fill channels 2,3,0 in auto mode (ptr -> 1), then channel 1 explicitly
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drv(1'b1, 32'h100 + 32'(i), 2'd0, 1'b1, 4'b0000);
      end
      @(negedge clk);
      drv(1'b1, 32'h11, 2'd1, 1'b0, 4'b0000);

      // Blocked channel 1 stalls the auto stream while others drain
      @(negedge clk);
      drv(1'b1, 32'h22, 2'd0, 1'b1, 4'b1101);
      #3;
      chk("blk_allfull", 32'(bus.o_valid), 32'hF);
      chk("blk_ptr", 32'(bus.o_ptr), 32'h1);
      chk("blk_ready", 32'(bus.o_ready), 32'h0);
      @(negedge clk);
      drv(1'b1, 32'h22, 2'd0, 1'b1, 4'b0010);
      #3;
      chk("blk_drained", 32'(bus.o_valid), 32'h2);
      chk("blk_ptr_hold", 32'(bus.o_ptr), 32'h1);
      chk("blk_release", 32'(bus.o_ready), 32'h1);
      @(negedge clk);
      drv(1'b0, 32'h0, 2'd0, 1'b0, 4'b0000);
      #3;
      chk("blk_data1", bus.o_data1, 32'h22);
      chk("blk_ptr2", 32'(bus.o_ptr), 32'h2);

      // Same-cycle load and drain on channel 3
      @(negedge clk);
      drv(1'b1, 32'h33, 2'd3, 1'b0, 4'b0000);
      @(negedge clk);
      drv(1'b1, 32'h44, 2'd3, 1'b0, 4'b1000);
      #3;
      chk("ld_dr_ready", 32'(bus.o_ready), 32'h1);
      @(negedge clk);
      drv(1'b0, 32'h0, 2'd0, 1'b0, 4'b1000);
      #3;
      chk("ld_dr_valid", 32'(bus.o_valid[3]), 32'h1);
      chk("ld_dr_data", bus.o_data3, 32'h44);
      @(negedge clk);
      drv(1'b0, 32'h0, 2'd0, 1'b0, 4'b0000);
      #3;
      chk("ld_dr_empty", 32'(bus.o_valid[3]), 32'h0);

      // Fill 0,2,3 explicitly (ch1 still holds 0x22, ptr=2), then reset
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drv(1'b1, 32'h200 + 32'(i), (i == 0) ? 2'd0 : 2'(i + 1), 1'b0, 4'b0000);
      end
      @(negedge clk);
      drv(1'b1, 32'hBAD0_0BAD, 2'd0, 1'b0, 4'b0000);
      rst = 1'b1;
      #3;
      chk("mid_allfull", 32'(bus.o_valid), 32'hF);
      chk("mid_ptr", 32'(bus.o_ptr), 32'h2);
      @(negedge clk);
      rst = 1'b0;
      drv(1'b0, 32'h0, 2'd0, 1'b0, 4'b0000);
      #3;
      chk("mid_rst_valid", 32'(bus.o_valid), 32'h0);
      chk("mid_rst_ptr", 32'(bus.o_ptr), 32'h0);
      for (int k = 0; k < 4; k++) chk("mid_rst_data", dut_data(k), 32'h0);

      // Stall stability on channel 0
      @(negedge clk);
      drv(1'b1, 32'hDEAD_BEEF, 2'd0, 1'b0, 4'b0000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drv(1'b1, $urandom, 2'd0, 1'b0, 4'b0000);
         #3;
         chk("stall_data", bus.o_data0, 32'hDEAD_BEEF);
         chk("stall_ready", 32'(bus.o_ready), 32'h0);
      end

      // Randomized traffic; an unaccepted word is held until taken
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         if (!(bus.i_valid && !m_acc)) begin
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.i_data  = $urandom;
         end
         bus.i_sel   = 2'($urandom_range(0, 3));
         bus.i_auto  = ($urandom_range(0, 1) == 1);
         bus.i_ready = 4'($urandom_range(0, 15));
      end

      @(negedge clk);
      #3;
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
